// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register with parallel load, hold,
// logical/rotate/arithmetic shifts and an LSB-first serialiser.
//
// Op handshake: an operation is taken on a posedge when op_valid=1 and busy=0.
// busy is the inverse of ready. While busy=1 every op input is ignored, and a
// request made in that window is dropped rather than queued. There is no
// backpressure on the serial output: sout is valid on every cycle with busy=1.
module univ_shift_reg #(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             din,
    input  logic                         sin_l,
    input  logic                         sin_r,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic                         busy,
    output logic                         done,
    output logic                         dbg_state,
    output logic [$clog2(WIDTH)-1:0]     dbg_count
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_SER  = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Below two bits there is nothing to shift between.
    if (WIDTH < 2) begin : g_width_check
        $error("univ_shift_reg: WIDTH must be >= 2");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] idle_next;
    logic            accept;

    // An op is accepted only when the serialiser is idle.
    assign accept = op_valid && (state == IDLE);

    // The serial bit is shown only while a word is in flight, otherwise 0.
    assign sout = busy & q[0];

    assign dbg_state = state;
    assign dbg_count = cnt;

    // Next register value for an accepted op while idle.
    always_comb begin
        idle_next = q;
        case (op)
            OP_HOLD: idle_next = q;
            OP_LOAD: idle_next = din;
            OP_SHL:  idle_next = {q[WIDTH-2:0], sin_r};
            OP_SHR:  idle_next = {sin_l, q[WIDTH-1:1]};
            OP_ROL:  idle_next = {q[WIDTH-2:0], q[WIDTH-1]};
            OP_ROR:  idle_next = {q[0], q[WIDTH-1:1]};
            OP_ASR:  idle_next = {q[WIDTH-1], q[WIDTH-1:1]};
            OP_SER:  idle_next = din;
            default: idle_next = q;
        endcase
    end

    // Register, serialiser FSM, bit counter and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RST_VAL;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        q <= idle_next;
                        if (op == OP_SER) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    // Zero fill, so q is empty by the time done pulses.
                    q <= {1'b0, q[WIDTH-1:1]};
                    if (cnt == LAST_CNT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Structural invariants of the serialiser.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(done && busy));
            assert (cnt <= LAST_CNT);
            assert (busy == (state == SHIFT));
        end
    end

endmodule
